s_axi4l_interface: RTL and testbench

S_AXI4L_INTERFACE -- requirements
Module: s_axi4l_interface

---
 rtl/snn_axi_pkg.sv | 11 +
 rtl/s_axi4l_interface.sv | 149 ++++++++++++++
 tb/tb_s_axi4l_interface.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/snn_axi_pkg.sv
// Shared address map and response codes for the SNN coprocessor AXI4-Lite slave.
package snn_axi_pkg;

    localparam int unsigned RESULT_IDX = 0;
    localparam int unsigned STATUS_IDX = 1;
    // Equals the default IMAGE_SIZE: control sits just past the pixel store.
    localparam int unsigned CTRL_IDX   = 256;

    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/s_axi4l_interface.sv
// AXI4-Lite slave that loads an image into the SNN coprocessor and returns its result.
// Registers are word-indexed directly by address (no byte offset).
module s_axi4l_interface
    import snn_axi_pkg::*;
#(
    parameter int unsigned N               = 256,
    parameter int unsigned M               = 8,
    parameter int unsigned AXI_DATA_WIDTH  = 32,
    parameter int unsigned AXI_ADDR_WIDTH  = 32,
    parameter int unsigned IMAGE_SIZE      = 256,
    parameter int unsigned IMAGE_SIZE_BITS = 8,
    parameter int unsigned PIXEL_MAX_VALUE = 255,
    parameter int unsigned PIXEL_BITS      = 8
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [AXI_ADDR_WIDTH-1:0]     AWADDR,
    input  logic [2:0]                    AWPROT,
    input  logic                          AWVALID,
    output logic                          AWREADY,
    input  logic [AXI_DATA_WIDTH-1:0]     WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0]   WSTRB,
    input  logic                          WVALID,
    output logic                          WREADY,
    output logic [1:0]                    BRESP,
    output logic                          BVALID,
    input  logic                          BREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]     ARADDR,
    input  logic [2:0]                    ARPROT,
    input  logic                          ARVALID,
    output logic                          ARREADY,
    output logic [AXI_DATA_WIDTH-1:0]     RDATA,
    output logic [1:0]                    RRESP,
    output logic                          RVALID,
    input  logic                          RREADY,
    input  logic [M-1:0]                  INFERED_DIGIT,
    output logic [PIXEL_BITS-1:0]         IMAGE [IMAGE_SIZE],
    output logic                          NEW_IMAGE
);

    localparam int unsigned IDX_W = IMAGE_SIZE_BITS + 1;
    localparam logic [IDX_W-1:0] L_RESULT = IDX_W'(RESULT_IDX);
    localparam logic [IDX_W-1:0] L_STATUS = IDX_W'(STATUS_IDX);
    localparam logic [IDX_W-1:0] L_CTRL   = IDX_W'(CTRL_IDX);
    localparam logic [IDX_W-1:0] L_NPIX   = IDX_W'(IMAGE_SIZE);

    logic                      r_awready;
    logic                      r_wready;
    logic                      r_bvalid;
    logic                      r_arready;
    logic                      r_rvalid;
    logic [AXI_DATA_WIDTH-1:0] r_rdata;
    logic                      r_ctrl;
    logic [PIXEL_BITS-1:0]     r_image_data [IMAGE_SIZE];

    logic                      w_wr_en;
    logic                      w_rd_en;
    logic [IDX_W-1:0]          w_wr_idx;
    logic [IDX_W-1:0]          w_rd_idx;
    logic [AXI_DATA_WIDTH-1:0] w_rd_data;
    logic                      w_unused;

    assign w_wr_idx = AWADDR[IDX_W-1:0];
    assign w_rd_idx = ARADDR[IDX_W-1:0];
    assign w_wr_en  = r_awready && r_wready && AWVALID && WVALID;
    assign w_rd_en  = r_arready && ARVALID;

    assign w_unused = ^{AWPROT, ARPROT, AWADDR[AXI_ADDR_WIDTH-1:IDX_W],
                        ARADDR[AXI_ADDR_WIDTH-1:IDX_W], WDATA[AXI_DATA_WIDTH-1:PIXEL_BITS],
                        WSTRB[AXI_DATA_WIDTH/8-1:1]};

    // Write channel: single-cycle AW/W ready pulse, blocked while a response is pending.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
        end else begin
            if (!r_awready && AWVALID && WVALID && !r_bvalid) begin
                r_awready <= 1'b1;
                r_wready  <= 1'b1;
            end else begin
                r_awready <= 1'b0;
                r_wready  <= 1'b0;
            end
            if (w_wr_en) begin
                r_bvalid <= 1'b1;
            end else if (r_bvalid && BREADY) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Register file: pixel store plus the control bit.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            for (int i = 0; i < IMAGE_SIZE; i++) begin
                r_image_data[i] <= '0;
            end
            r_ctrl <= 1'b0;
        end else if (w_wr_en) begin
            if (w_wr_idx < L_NPIX) begin
                if (WSTRB[0]) begin
                    r_image_data[w_wr_idx[IMAGE_SIZE_BITS-1:0]] <= WDATA[PIXEL_BITS-1:0];
                end
            end else if (w_wr_idx == L_CTRL) begin
                r_ctrl <= WDATA[0];
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        if (w_rd_idx == L_RESULT) begin
            w_rd_data[M-1:0] = INFERED_DIGIT;
        end else if (w_rd_idx == L_STATUS) begin
            w_rd_data[0] = r_ctrl;
        end
    end

    // Read channel: RDATA only loads on the address handshake, so it holds under backpressure.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_arready <= !r_arready && ARVALID && !r_rvalid;
            if (w_rd_en) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
            end else if (r_rvalid && RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign AWREADY   = r_awready;
    assign WREADY    = r_wready;
    assign BVALID    = r_bvalid;
    assign BRESP     = RESP_OKAY;
    assign ARREADY   = r_arready;
    assign RVALID    = r_rvalid;
    assign RDATA     = r_rdata;
    assign RRESP     = RESP_OKAY;
    assign NEW_IMAGE = r_ctrl;
    assign IMAGE     = r_image_data;

endmodule

// File: tb/tb_s_axi4l_interface.sv
// Scoreboard bench for s_axi4l_interface: expected responses queued at issue, checked on arrival.
module tb_s_axi4l_interface;

    logic        ACLK;
    logic        ARESETN;
    logic [31:0] AWADDR;
    logic [2:0]  AWPROT;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic [2:0]  ARPROT;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;
    logic [7:0]  INFERED_DIGIT;
    logic [7:0]  IMAGE [256];
    logic        NEW_IMAGE;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [1:0]  q_b [$];
    logic [31:0] q_r [$];
    logic [7:0]  img_model [256];
    logic        ctrl_model;

    s_axi4l_interface u_dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .AWADDR        (AWADDR),
        .AWPROT        (AWPROT),
        .AWVALID       (AWVALID),
        .AWREADY       (AWREADY),
        .WDATA         (WDATA),
        .WSTRB         (WSTRB),
        .WVALID        (WVALID),
        .WREADY        (WREADY),
        .BRESP         (BRESP),
        .BVALID        (BVALID),
        .BREADY        (BREADY),
        .ARADDR        (ARADDR),
        .ARPROT        (ARPROT),
        .ARVALID       (ARVALID),
        .ARREADY       (ARREADY),
        .RDATA         (RDATA),
        .RRESP         (RRESP),
        .RVALID        (RVALID),
        .RREADY        (RREADY),
        .INFERED_DIGIT (INFERED_DIGIT),
        .IMAGE         (IMAGE),
        .NEW_IMAGE     (NEW_IMAGE)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input bit hold_b);
        bit seen;
        AWADDR  = addr;
        WDATA   = data;
        WSTRB   = strb;
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        BREADY  = !hold_b;
        q_b.push_back(2'b00);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(posedge ACLK); #1;
            if (AWREADY) seen = 1'b1;
        end
        check("aw_handshake", {31'b0, seen}, 32'd1);
        if (!seen) begin
            AWVALID = 1'b0;
            WVALID  = 1'b0;
            void'(q_b.pop_front());
            return;
        end
        check("wready", {31'b0, WREADY}, 32'd1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        if (addr < 256) begin
            if (strb[0]) img_model[addr] = data[7:0];
        end else if (addr == 256) begin
            ctrl_model = data[0];
        end
        check("awready_pulse", {31'b0, AWREADY}, 32'd0);
        check("bvalid", {31'b0, BVALID}, 32'd1);
        if (BVALID) check("bresp", {30'b0, BRESP}, {30'b0, q_b.pop_front()});
        if (hold_b) return;
        @(posedge ACLK); #1;
        check("bvalid_clr", {31'b0, BVALID}, 32'd0);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp, input int hold);
        bit seen;
        logic [31:0] exp_d;
        exp_d   = exp;
        ARADDR  = addr;
        ARVALID = 1'b1;
        RREADY  = (hold == 0);
        q_r.push_back(exp);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(posedge ACLK); #1;
            if (ARREADY) seen = 1'b1;
        end
        check("ar_handshake", {31'b0, seen}, 32'd1);
        if (!seen) begin
            ARVALID = 1'b0;
            void'(q_r.pop_front());
            return;
        end
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        check("arready_pulse", {31'b0, ARREADY}, 32'd0);
        check("rvalid", {31'b0, RVALID}, 32'd1);
        check("rresp", {30'b0, RRESP}, 32'd0);
        if (RVALID) begin
            exp_d = q_r.pop_front();
            check("rdata", RDATA, exp_d);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge ACLK); #1;
            check("rvalid_hold", {31'b0, RVALID}, 32'd1);
            check("rdata_hold", RDATA, exp_d);
        end
        RREADY = 1'b1;
        @(posedge ACLK); #1;
        check("rvalid_clr", {31'b0, RVALID}, 32'd0);
    endtask

    initial begin
        int a;
        logic [7:0] d;
        ARESETN       = 1'b0;
        AWADDR        = '0;
        AWPROT        = '0;
        AWVALID       = 1'b0;
        WDATA         = '0;
        WSTRB         = '0;
        WVALID        = 1'b0;
        BREADY        = 1'b1;
        ARADDR        = '0;
        ARPROT        = '0;
        ARVALID       = 1'b0;
        RREADY        = 1'b1;
        INFERED_DIGIT = '0;
        ctrl_model    = 1'b0;
        for (int i = 0; i < 256; i++) img_model[i] = '0;

        repeat (3) @(posedge ACLK);
        #1;
        check("rst_awready", {31'b0, AWREADY}, 32'd0);
        check("rst_bvalid", {31'b0, BVALID}, 32'd0);
        check("rst_rvalid", {31'b0, RVALID}, 32'd0);
        check("rst_rdata", RDATA, 32'd0);
        check("rst_new_image", {31'b0, NEW_IMAGE}, 32'd0);
        check("rst_image3", {24'b0, IMAGE[3]}, 32'd0);
        ARESETN = 1'b1;
        @(posedge ACLK); #1;

        axi_write(32'd0, 32'h2A, 4'h1, 1'b0);
        axi_write(32'd1, 32'hC8, 4'h1, 1'b0);
        check("image0", {24'b0, IMAGE[0]}, {24'b0, img_model[0]});
        check("image1", {24'b0, IMAGE[1]}, {24'b0, img_model[1]});
        check("image0_abs", {24'b0, IMAGE[0]}, 32'd42);

        axi_write(32'd256, 32'd1, 4'h1, 1'b0);
        check("new_image_set", {31'b0, NEW_IMAGE}, {31'b0, ctrl_model});
        axi_write(32'd256, 32'd0, 4'h1, 1'b0);
        check("new_image_clr", {31'b0, NEW_IMAGE}, {31'b0, ctrl_model});

        INFERED_DIGIT = 8'h5B;
        axi_read(32'd0, 32'h0000005B, 0);

        axi_write(32'd5, 32'hFF, 4'h0, 1'b0);
        check("image5_nostrb", {24'b0, IMAGE[5]}, {24'b0, img_model[5]});

        axi_read(32'd0, 32'h0000005B, 5);

        axi_write(32'd300, 32'h77, 4'h1, 1'b0);
        check("image44_ignored", {24'b0, IMAGE[44]}, {24'b0, img_model[44]});
        check("ctrl_ignored", {31'b0, NEW_IMAGE}, {31'b0, ctrl_model});

        for (int k = 0; k < 6; k++) begin
            a = $urandom_range(2, 255);
            d = 8'($urandom);
            axi_write(a, {24'b0, d}, 4'h1, 1'b0);
            check("image_rand", {24'b0, IMAGE[a]}, {24'b0, img_model[a]});
        end

        axi_write(32'd7, 32'h99, 4'h1, 1'b0);
        axi_read(32'd7, 32'd0, 0);
        axi_write(32'd256, 32'd1, 4'h1, 1'b0);
        axi_read(32'd1, {31'b0, ctrl_model}, 0);

        INFERED_DIGIT = 8'h13;
        fork
            axi_write(32'd256, 32'd0, 4'h1, 1'b0);
            axi_read(32'd0, 32'h00000013, 0);
        join
        check("simul_ctrl", {31'b0, NEW_IMAGE}, {31'b0, ctrl_model});

        axi_write(32'd256, 32'd1, 4'h1, 1'b1);
        ARESETN = 1'b0;
        @(posedge ACLK); #1;
        check("rst_mid_bvalid", {31'b0, BVALID}, 32'd0);
        check("rst_mid_new_image", {31'b0, NEW_IMAGE}, 32'd0);
        check("rst_mid_image0", {24'b0, IMAGE[0]}, 32'd0);
        ARESETN = 1'b1;
        BREADY  = 1'b1;
        @(posedge ACLK); #1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
